// File: rtl/clint_n_if.sv
// Single-beat AXI4-lite-style register bus for the core-local interruptor.
interface clint_n_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/clint_n.sv
// Core-local interruptor: per-hart MSIP/SSIP, shared prescaled 64-bit mtime,
// per-hart mtimecmp driving registered machine timer interrupts.
module clint_n #(
    parameter int unsigned NUM_HARTS = 2,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    clint_n_if.slave             bus,
    output logic [NUM_HARTS-1:0] ipi_m_o,
    output logic [NUM_HARTS-1:0] ipi_s_o,
    output logic [NUM_HARTS-1:0] tmr_m_o,
    output logic                 write_complete
);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {K_NONE, K_MSIP, K_MTCMP, K_MTIME, K_SSIP} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [3:0] idx;
        logic       hi;
    } dec_t;
    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    // Map a 16-bit offset onto a register; K_NONE marks a decode error.
    function automatic dec_t decode(input logic [15:0] off);
        dec_t d;
        d.kind = K_NONE;
        d.idx  = off[5:2];
        d.hi   = off[2];
        if (off[1:0] == 2'b00) begin
            if (off < 16'(4 * NUM_HARTS)) begin
                d.kind = K_MSIP;
            end else if (off >= 16'h4000 && off < 16'(32'h4000 + 8 * NUM_HARTS)) begin
                d.kind = K_MTCMP;
                d.idx  = off[6:3];
            end else if (off[15:3] == 13'h17FF) begin
                d.kind = K_MTIME;
            end else if (off >= 16'hC000 && off < 16'(32'hC000 + 4 * NUM_HARTS)) begin
                d.kind = K_SSIP;
            end
        end
        return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    wstate_e               wstate;
    rstate_e               rstate;
    logic                  aw_held, w_held;
    logic [15:0]           aw_off_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [PRE_W-1:0]      pre;
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0]  msip, ssip, tmr_q;

    logic                  aw_fire_c, w_fire_c, commit_c, tick_c;
    logic [15:0]           wr_off_c;
    logic [31:0]           wr_data_c, rd_data_c;
    logic [3:0]            wr_strb_c;
    dec_t                  wr_dec_c, rd_dec_c;
    logic                  unused_c;

    assign unused_c = ^{bus.wlast, bus.awaddr[31:16], bus.araddr[31:16]};

    // Merge held and live AW/W beats; a write commits once both are present.
    always_comb begin
        aw_fire_c = bus.awvalid & bus.awready;
        w_fire_c  = bus.wvalid & bus.wready;
        wr_off_c  = aw_held ? aw_off_q : bus.awaddr[15:0];
        wr_data_c = w_held ? wdata_q : bus.wdata;
        wr_strb_c = w_held ? wstrb_q : bus.wstrb;
        commit_c  = (wstate == W_IDLE) & (aw_held | aw_fire_c) & (w_held | w_fire_c);
        wr_dec_c  = decode(wr_off_c);
        rd_dec_c  = decode(bus.araddr[15:0]);
        tick_c    = (pre == PRE_W'(TICK_DIV - 1));
    end

    always_comb begin
        rd_data_c = '0;
        if (rd_dec_c.kind == K_MTIME) rd_data_c = rd_dec_c.hi ? mtime[63:32] : mtime[31:0];
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (rd_dec_c.idx == 4'(h)) begin
                case (rd_dec_c.kind)
                    K_MSIP:  rd_data_c = {31'd0, msip[h]};
                    K_SSIP:  rd_data_c = {31'd0, ssip[h]};
                    K_MTCMP: rd_data_c = rd_dec_c.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
                    default: ;
                endcase
            end
        end
    end

    // Write channel FSM.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate         <= W_IDLE;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_off_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bus.awready    <= 1'b0;
            bus.wready     <= 1'b0;
            bus.bvalid     <= 1'b0;
            bus.bresp      <= 2'b00;
            write_complete <= 1'b0;
        end else begin
            write_complete <= 1'b0;
            case (wstate)
                W_IDLE: begin
                    if (commit_c) begin
                        wstate         <= W_RESP;
                        aw_held        <= 1'b0;
                        w_held         <= 1'b0;
                        bus.awready    <= 1'b0;
                        bus.wready     <= 1'b0;
                        bus.bvalid     <= 1'b1;
                        bus.bresp      <= (wr_dec_c.kind == K_NONE) ? 2'b10 : 2'b00;
                        write_complete <= 1'b1;
                    end else begin
                        aw_held     <= aw_held | aw_fire_c;
                        w_held      <= w_held | w_fire_c;
                        bus.awready <= ~(aw_held | aw_fire_c);
                        bus.wready  <= ~(w_held | w_fire_c);
                        if (aw_fire_c) aw_off_q <= bus.awaddr[15:0];
                        if (w_fire_c) begin
                            wdata_q <= bus.wdata;
                            wstrb_q <= bus.wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        wstate      <= W_IDLE;
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; rdata is sampled at the AR handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate      <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
        end else begin
            case (rstate)
                R_IDLE: begin
                    bus.arready <= 1'b1;
                    if (bus.arvalid && bus.arready) begin
                        rstate      <= R_DATA;
                        bus.arready <= 1'b0;
                        bus.rvalid  <= 1'b1;
                        bus.rlast   <= 1'b1;
                        bus.rdata   <= rd_data_c;
                        bus.rresp   <= (rd_dec_c.kind == K_NONE) ? 2'b10 : 2'b00;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        rstate      <= R_IDLE;
                        bus.rvalid  <= 1'b0;
                        bus.rlast   <= 1'b0;
                        bus.arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Register file, timer and interrupt compare; bus writes beat the tick.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pre   <= '0;
            mtime <= '0;
            msip  <= '0;
            ssip  <= '0;
            tmr_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            pre <= tick_c ? '0 : pre + PRE_W'(1);
            if (commit_c && wr_dec_c.kind == K_MTIME) begin
                if (wr_dec_c.hi) mtime[63:32] <= merge(mtime[63:32], wr_data_c, wr_strb_c);
                else             mtime[31:0]  <= merge(mtime[31:0], wr_data_c, wr_strb_c);
            end else if (tick_c) begin
                mtime <= mtime + 64'd1;
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (commit_c && wr_dec_c.idx == 4'(h)) begin
                    if (wr_dec_c.kind == K_MSIP && wr_strb_c[0]) msip[h] <= wr_data_c[0];
                    if (wr_dec_c.kind == K_SSIP && wr_strb_c[0]) ssip[h] <= wr_data_c[0];
                    if (wr_dec_c.kind == K_MTCMP) begin
                        if (wr_dec_c.hi)
                            mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wr_data_c, wr_strb_c);
                        else
                            mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wr_data_c, wr_strb_c);
                    end
                end
                tmr_q[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    assign ipi_m_o = msip;
    assign ipi_s_o = ssip;
    assign tmr_m_o = tmr_q;
endmodule

// File: tb/tb_clint_n.sv
// Directed bench for clint_n (4 harts, mtime ticks every 4 cycles) with
// response scoreboards and a cycle-level mtime reference.
module tb_clint_n;
    localparam int unsigned NH = 4;
    localparam int          TD = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic [NH-1:0] ipi_m, ipi_s, tmr;
    logic          wc;

    always #5 aclk = ~aclk;

    clint_n_if bus ();

    clint_n #(.NUM_HARTS(NH), .TICK_DIV(TD)) dut (
        .aclk(aclk), .areset(areset), .bus(bus),
        .ipi_m_o(ipi_m), .ipi_s_o(ipi_s), .tmr_m_o(tmr), .write_complete(wc)
    );

    int errors = 0;
    int checks = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    // mtime reference: cycles since reset release and pending mtime write
    logic [63:0] m_time;
    int          m_pre, cyc;
    logic        m_wr = 1'b0;
    logic        m_hi = 1'b0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_ws = '0;

    function automatic logic [31:0] bytes_upd(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge aclk) begin
        if (areset) begin
            m_time <= '0;
            m_pre  <= 0;
            cyc    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_wr)
                m_time <= m_hi ? {bytes_upd(m_time[63:32], m_wd, m_ws), m_time[31:0]}
                               : {m_time[63:32], bytes_upd(m_time[31:0], m_wd, m_ws)};
            else if (m_pre == TD - 1)
                m_time <= m_time + 64'd1;
            m_pre <= (m_pre == TD - 1) ? 0 : m_pre + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        idle_bus();
        @(posedge aclk); @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk);
    endtask

    // Issue AW/W (W optionally leading AW by w_lead cycles); returns the cycle after commit.
    task automatic write_req(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp);
        int n = 0;
        while (!(bus.awready && bus.wready) && n < 50) begin @(negedge aclk); n++; end
        check("w_ready", 64'({bus.awready, bus.wready}), 64'(2'b11));
        bq.push_back(exp_resp);
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        for (int i = 0; i < w_lead; i++) begin
            @(posedge aclk); @(negedge aclk);
            bus.wvalid = 1'b0;
            check("w_lead_no_commit", 64'({wc, bus.bvalid}), 64'(2'b00));
        end
        bus.awaddr = addr; bus.awvalid = 1'b1;
        if (addr[15:3] == 13'h17FF && addr[1:0] == 2'b00) begin
            m_wr = 1'b1; m_hi = addr[2]; m_wd = data; m_ws = strb;
        end
        @(posedge aclk); @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; m_wr = 1'b0;
        check("wc_pulse", 64'(wc), 64'(1));
        check("bvalid", 64'(bus.bvalid), 64'(1));
    endtask

    task automatic write_resp(input int b_hold);
        logic [1:0] e;
        e = bq.pop_front();
        for (int i = 0; i < b_hold; i++) begin
            @(posedge aclk); @(negedge aclk);
            check("bvalid_hold", 64'({bus.bvalid, bus.bresp, wc}), 64'({1'b1, e, 1'b0}));
        end
        check("bresp", 64'(bus.bresp), 64'(e));
        bus.bready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        bus.bready = 1'b0;
        check("b_done", 64'({bus.bvalid, wc, bus.awready}), 64'(3'b001));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int r_hold, input bit use_mtime);
        int n = 0;
        logic [33:0] e;
        while (!bus.arready && n < 50) begin @(negedge aclk); n++; end
        check("ar_ready", 64'(bus.arready), 64'(1));
        if (use_mtime) exp_data = addr[2] ? m_time[63:32] : m_time[31:0];
        rq.push_back({exp_resp, exp_data});
        bus.araddr = addr; bus.arvalid = 1'b1;
        @(posedge aclk); @(negedge aclk);
        bus.arvalid = 1'b0;
        check("rvalid_rlast", 64'({bus.rvalid, bus.rlast, bus.arready}), 64'(3'b110));
        e = rq.pop_front();
        for (int i = 0; i < r_hold; i++) begin
            @(posedge aclk); @(negedge aclk);
            check("r_hold", 64'({bus.rvalid, bus.rdata}), 64'({1'b1, e[31:0]}));
        end
        check("rdata", 64'(bus.rdata), 64'(e[31:0]));
        check("rresp", 64'(bus.rresp), 64'(e[33:32]));
        bus.rready = 1'b1;
        @(posedge aclk); @(negedge aclk);
        bus.rready = 1'b0;
        check("r_done", 64'({bus.rvalid, bus.arready}), 64'(2'b01));
    endtask

    initial begin
        areset = 1'b1;
        idle_bus();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("reset_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'(0));
        check("reset_resp", 64'({bus.bvalid, bus.rvalid, bus.rlast, wc, bus.bresp, bus.rresp}), 64'(0));
        check("reset_irq", 64'({ipi_m, ipi_s, tmr}), 64'(0));
        check("reset_rdata", 64'(bus.rdata), 64'(0));
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk);
        check("ready_after_reset", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));

        // Timer compare: mtimecmp[1] = 0x10 fires after 64 ticks of aclk.
        write_req(32'h4008, 32'h10, 4'hF, 0, 2'b00); write_resp(0);
        write_req(32'h400C, 32'h0, 4'hF, 0, 2'b00); write_resp(0);
        while (cyc < 64) @(negedge aclk);
        check("tmr_before", 64'(tmr), 64'(4'b0000));
        @(negedge aclk);
        check("tmr_rise", 64'(tmr), 64'(4'b0010));
        write_req(32'h400C, 32'h1, 4'hF, 0, 2'b00);
        check("tmr_still_n1", 64'(tmr), 64'(4'b0010));
        write_resp(0);
        check("tmr_clear_n2", 64'(tmr), 64'(4'b0000));
        axi_read(32'h4008, 32'h10, 2'b00, 0, 1'b0);
        axi_read(32'h400C, 32'h1, 2'b00, 0, 1'b0);

        // Software interrupts.
        write_req(32'h0008, 32'h1, 4'hF, 0, 2'b00);
        check("ipi_m_hart2", 64'(ipi_m), 64'(4'b0100));
        write_resp(0);
        write_req(32'hC00C, 32'h1, 4'hF, 0, 2'b00);
        check("ipi_s_hart3", 64'({ipi_m, ipi_s}), 64'({4'b0100, 4'b1000}));
        write_resp(0);
        write_req(32'h0004, 32'h1, 4'b1110, 0, 2'b00); write_resp(0);
        check("msip_no_strb0", 64'(ipi_m), 64'(4'b0100));
        axi_read(32'h0008, 32'h1, 2'b00, 0, 1'b0);
        axi_read(32'hC00C, 32'h1, 2'b00, 0, 1'b0);
        axi_read(32'h0004, 32'h0, 2'b00, 0, 1'b0);

        // W leads AW by two cycles; B and R back-pressured.
        write_req(32'h0000, 32'hFFFF_FFFF, 4'hF, 2, 2'b00);
        check("ipi_m_lead", 64'(ipi_m), 64'(4'b0101));
        write_resp(3);
        axi_read(32'h0000, 32'h1, 2'b00, 2, 1'b0);

        // Byte strobes on mtimecmp.
        write_req(32'h4010, 32'h1234_5678, 4'b0101, 0, 2'b00); write_resp(0);
        axi_read(32'h4010, 32'hFF34_FF78, 2'b00, 0, 1'b0);
        axi_read(32'h4014, 32'hFFFF_FFFF, 2'b00, 0, 1'b0);

        // Same-cycle read and write of msip[3]: read sees the old value.
        fork
            begin write_req(32'h000C, 32'h1, 4'hF, 0, 2'b00); write_resp(0); end
            axi_read(32'h000C, 32'h0, 2'b00, 0, 1'b0);
        join
        check("ipi_m_concurrent", 64'(ipi_m), 64'(4'b1101));

        // Decode errors and address aliasing.
        axi_read(32'h8000, 32'h0, 2'b10, 0, 1'b0);
        axi_read(32'h0002, 32'h0, 2'b10, 0, 1'b0);
        axi_read(32'h4020, 32'h0, 2'b10, 0, 1'b0);
        write_req(32'h8000, 32'h1, 4'hF, 0, 2'b10); write_resp(0);
        write_req(32'h0011, 32'h1, 4'hF, 0, 2'b10); write_resp(0);
        write_req(32'h0010, 32'h1, 4'hF, 0, 2'b10); write_resp(0);
        write_req(32'hC002, 32'h1, 4'hF, 0, 2'b10); write_resp(0);
        check("decerr_no_effect", 64'({ipi_m, ipi_s}), 64'({4'b1101, 4'b1000}));
        axi_read(32'hFFFF_0008, 32'h1, 2'b00, 0, 1'b0);

        // mtime wrap from all ones.
        do_reset();
        write_req(32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 2'b00); write_resp(0);
        write_req(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 2'b00); write_resp(0);
        check("tmr_all_at_max", 64'(tmr), 64'(4'b1111));
        repeat (6) @(negedge aclk);
        check("tmr_after_wrap", 64'(tmr), 64'(4'b0000));
        axi_read(32'hBFF8, 32'h0, 2'b00, 0, 1'b1);
        axi_read(32'hBFFC, 32'h0, 2'b00, 0, 1'b1);
        write_req(32'hBFF8, 32'h0000_AB00, 4'b0010, 0, 2'b00); write_resp(0);
        axi_read(32'hBFF8, 32'h0, 2'b00, 1, 1'b1);

        // Reset while the write response is pending.
        write_req(32'h0000, 32'h1, 4'hF, 0, 2'b00);
        check("msip0_set", 64'(ipi_m), 64'(4'b0001));
        areset = 1'b1;
        bq.delete();
        @(posedge aclk); @(negedge aclk);
        check("abort_state", 64'({bus.bvalid, ipi_m, bus.awready}), 64'(0));
        areset = 1'b0;
        @(posedge aclk); @(negedge aclk);
        check("abort_ready", 64'({bus.awready, bus.wready, bus.bvalid}), 64'(3'b110));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
